// File: rtl/nonconsec_pattern_gen_pkg.sv
// Shared types and default widths for the non-consecutive repetition pattern generator.
package nonconsec_pkg;

    localparam int DEF_CNT_W = 4;
    localparam int DEF_GAP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIT  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } gen_state_t;

endpackage

// File: rtl/nonconsec_pattern_gen_if.sv
// Control and monitor-facing signal bundle of the pattern generator.
interface nonconsec_pattern_gen_if #(
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
);
    logic             start;
    logic [CNT_W-1:0] hits;
    logic [GAP_W-1:0] gap;
    logic             decoy_en;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_cnt;

    modport master (
        output start, hits, gap, decoy_en,
        input  a, b, busy, done, hit_cnt
    );

    modport slave (
        input  start, hits, gap, decoy_en,
        output a, b, busy, done, hit_cnt
    );
endinterface

// File: rtl/nonconsec_pattern_gen_gap_timer.sv
// Loadable down-counter timing the idle cycles between coincidences.
module gap_timer #(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [GAP_W-1:0] len,
    output logic [GAP_W-1:0] value,
    output logic             last,
    output logic [GAP_W-1:0] index
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= len;
        end else if (value != '0) begin
            value <= value - GAP_W'(1);
        end
    end

    assign last  = (value == GAP_W'(1));
    // 1-based position inside the current gap; len must stay stable while counting
    assign index = len - value + GAP_W'(1);

endmodule

// File: rtl/nonconsec_pattern_gen.sv
// Emits N single-cycle a&&b coincidences separated by programmable idle gaps,
// optionally filling the first gap cycles with a-only / b-only decoys.
//
// state | meaning
// IDLE  | waiting for start; a=b=0
// HIT   | one-cycle a=b=1 coincidence
// GAP   | idle/decoy cycles between coincidences
// DONE  | one-cycle done pulse
module nonconsec_pattern_gen
    import nonconsec_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic                    clk,
    input  logic                    reset,
    nonconsec_pattern_gen_if.slave  ifc
);

    gen_state_t       state, state_nx;
    logic [CNT_W-1:0] hits_l;
    logic [GAP_W-1:0] gap_l;
    logic             decoy_l;
    logic             latch;
    logic             a_nx, b_nx, busy_nx, done_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             tmr_load;
    logic             tmr_last;
    logic [GAP_W-1:0] tmr_value;
    logic [GAP_W-1:0] tmr_index;
    logic [GAP_W-1:0] gap_eff;

    assign gap_eff = (ifc.gap == '0) ? GAP_W'(1) : ifc.gap;

    gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .len   (gap_l),
        .value (tmr_value),
        .last  (tmr_last),
        .index (tmr_index)
    );

    // Outputs are computed for the next state so they register on the same edge.
    always_comb begin
        state_nx = state;
        a_nx     = 1'b0;
        b_nx     = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        cnt_nx   = ifc.hit_cnt;
        latch    = 1'b0;
        tmr_load = 1'b0;
        case (state)
            IDLE: begin
                if (ifc.start) begin
                    if (ifc.hits != '0) begin
                        latch    = 1'b1;
                        state_nx = HIT;
                        a_nx     = 1'b1;
                        b_nx     = 1'b1;
                        busy_nx  = 1'b1;
                        cnt_nx   = CNT_W'(1);
                    end else begin
                        done_nx = 1'b1;
                        cnt_nx  = '0;
                    end
                end
            end
            HIT: begin
                if (ifc.hit_cnt == hits_l) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = GAP;
                    tmr_load = 1'b1;
                    busy_nx  = 1'b1;
                    a_nx     = decoy_l;
                end
            end
            GAP: begin
                busy_nx = 1'b1;
                if (tmr_last) begin
                    state_nx = HIT;
                    a_nx     = 1'b1;
                    b_nx     = 1'b1;
                    cnt_nx   = ifc.hit_cnt + CNT_W'(1);
                end else begin
                    b_nx = decoy_l && (tmr_index == GAP_W'(1));
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ifc.a       <= 1'b0;
            ifc.b       <= 1'b0;
            ifc.busy    <= 1'b0;
            ifc.done    <= 1'b0;
            ifc.hit_cnt <= '0;
        end else begin
            state       <= state_nx;
            ifc.a       <= a_nx;
            ifc.b       <= b_nx;
            ifc.busy    <= busy_nx;
            ifc.done    <= done_nx;
            ifc.hit_cnt <= cnt_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits_l  <= '0;
            gap_l   <= '0;
            decoy_l <= 1'b0;
        end else if (latch) begin
            hits_l  <= ifc.hits;
            gap_l   <= gap_eff;
            decoy_l <= ifc.decoy_en;
        end
    end

endmodule
